// File: rtl/stepdir_accel.sv
// Step/dir pulse generator. It pops queued moves from a FIFO and shapes the step
// interval per step (interval += add, add += add2), with dir setup and late-step flags.
module stepdir_accel #(
   parameter int INTERVAL_BITS    = 32,
   parameter int COUNT_BITS       = 32,
   parameter int ADD_BITS         = 32,
   parameter int ADD2_BITS        = 16,
   parameter int QUEUE_DEPTH      = 512,
   parameter int PULSE_CYCLES     = 8,
   parameter int DIR_SETUP_CYCLES = 4
) (
   input  logic                                                  clk,
   input  logic                                                  reset,
   input  logic [31:0]                                           clock,
   input  logic [INTERVAL_BITS+COUNT_BITS+ADD_BITS+ADD2_BITS:0]  queue_wr_data,
   input  logic                                                  queue_wr_en,
   output logic                                                  queue_full,
   output logic                                                  queue_empty,
   output logic [$clog2(QUEUE_DEPTH):0]                          queue_level,
   input  logic                                                  dedge,
   input  logic                                                  do_reset_clock,
   input  logic [31:0]                                           reset_clock,
   output logic                                                  step,
   output logic                                                  dir,
   output logic [31:0]                                           position,
   output logic                                                  missed_clock,
   output logic                                                  queue_overflow,
   output logic                                                  idle
);

   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int QW = 1 + INTERVAL_BITS + COUNT_BITS + ADD_BITS + ADD2_BITS;
   localparam int PW = $clog2(PULSE_CYCLES) + 1;
   localparam int SW = $clog2(DIR_SETUP_CYCLES) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DIRSET,
      S_WAIT
   } state_t;

   state_t state;

   logic [QW-1:0] mem [QUEUE_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   logic          push;
   logic          pop;

   logic [QW-1:0]            q_data;
   logic                     q_dir;
   logic [INTERVAL_BITS-1:0] q_interval;
   logic [COUNT_BITS-1:0]    q_count;
   logic [ADD_BITS-1:0]      q_add;
   logic [ADD2_BITS-1:0]     q_add2;

   logic [31:0]              next_step;
   logic [INTERVAL_BITS-1:0] interval_r;
   logic [ADD_BITS-1:0]      add_r;
   logic [ADD2_BITS-1:0]     add2_r;
   logic [COUNT_BITS-1:0]    count_r;
   logic                     next_dir;
   logic [PW-1:0]            pulse_left;
   logic [SW-1:0]            setup_cnt;
   logic                     dir_applied;

   logic [31:0]              since_due;
   logic [31:0]              lead;
   logic                     due;
   logic                     spacing_ok;
   logic                     emit;
   logic [INTERVAL_BITS-1:0] interval_nxt;
   logic [ADD_BITS-1:0]      add_nxt;
   logic [COUNT_BITS-1:0]    count_nxt;

   assign queue_full  = (level == (AW+1)'(QUEUE_DEPTH));
   assign queue_empty = (level == '0);
   assign queue_level = level;
   assign idle        = (state == S_IDLE) && queue_empty;

   assign push = queue_wr_en && !queue_full;
   assign pop  = (state == S_IDLE) && !queue_empty;

   assign q_data     = mem[rd_ptr];
   assign q_add2     = q_data[ADD2_BITS-1:0];
   assign q_add      = q_data[ADD2_BITS +: ADD_BITS];
   assign q_count    = q_data[ADD2_BITS+ADD_BITS +: COUNT_BITS];
   assign q_interval = q_data[ADD2_BITS+ADD_BITS+COUNT_BITS +: INTERVAL_BITS];
   assign q_dir      = q_data[QW-1];

   // Wrap-safe time compares: due once clock has reached next_step within half the
   // 32-bit range, late at load if next_step already sits in the last quarter behind.
   assign since_due  = clock - next_step;
   assign lead       = next_step - clock;
   assign due        = (since_due < 32'h8000_0000);
   assign spacing_ok = dedge ? (pulse_left == '0) : !step;
   assign emit       = (state == S_WAIT) && due && spacing_ok;

   assign interval_nxt = interval_r + INTERVAL_BITS'($signed(add_r));
   assign add_nxt      = add_r + ADD_BITS'($signed(add2_r));
   assign count_nxt    = count_r - 1'b1;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= queue_wr_data;
      end
   end

   // A push while full is dropped and latched as overflow, even alongside a pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         queue_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (!push && pop) begin
            level <= level - 1'b1;
         end
         if (queue_wr_en && queue_full) begin
            queue_overflow <= 1'b1;
         end
      end
   end

   // Move engine. The pulse timer runs independently of the state so a new move can
   // load while the last pulse of the previous one is still high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         next_step    <= '0;
         interval_r   <= '0;
         add_r        <= '0;
         add2_r       <= '0;
         count_r      <= '0;
         next_dir     <= 1'b0;
         pulse_left   <= '0;
         setup_cnt    <= '0;
         dir_applied  <= 1'b0;
         step         <= 1'b0;
         dir          <= 1'b0;
         position     <= '0;
         missed_clock <= 1'b0;
      end else begin
         if (pulse_left != '0) begin
            pulse_left <= pulse_left - 1'b1;
         end else if (!dedge) begin
            step <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (!queue_empty) begin
                  interval_r <= q_interval;
                  add_r      <= q_add;
                  add2_r     <= q_add2;
                  count_r    <= q_count;
                  next_dir   <= q_dir;
                  next_step  <= next_step + 32'(q_interval);
                  state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (lead >= 32'hC000_0000) begin
                  missed_clock <= 1'b1;
               end
               if (count_r == '0) begin
                  state <= S_IDLE;
               end else if (next_dir != dir) begin
                  state <= S_DIRSET;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_DIRSET: begin
               if (!dir_applied) begin
                  if (spacing_ok) begin
                     dir         <= next_dir;
                     setup_cnt   <= SW'(DIR_SETUP_CYCLES - 1);
                     dir_applied <= 1'b1;
                  end
               end else if (setup_cnt == '0) begin
                  dir_applied <= 1'b0;
                  state       <= S_WAIT;
               end else begin
                  setup_cnt <= setup_cnt - 1'b1;
               end
            end
            S_WAIT: begin
               if (emit) begin
                  step       <= dedge ? !step : 1'b1;
                  pulse_left <= PW'(PULSE_CYCLES - 1);
                  position   <= dir ? position + 32'd1 : position - 32'd1;
                  count_r    <= count_nxt;
                  if (clock != next_step) begin
                     missed_clock <= 1'b1;
                  end
                  if (count_nxt == '0) begin
                     state <= S_IDLE;
                  end else begin
                     interval_r <= interval_nxt;
                     add_r      <= add_nxt;
                     next_step  <= next_step + 32'(interval_nxt);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase

         if (do_reset_clock) begin
            next_step <= reset_clock;
         end
      end
   end

endmodule

// File: tb/tb_stepdir_accel.sv
// Directed bench for stepdir_accel: a table of single moves with hand-computed step
// times, plus sequences for dir change, dwell, dedge, late steps, FIFO fill and reset.
module tb_stepdir_accel;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  sys_time = 32'd0;
   logic [112:0] queue_wr_data;
   logic         queue_wr_en;
   logic         queue_full;
   logic         queue_empty;
   logic [9:0]   queue_level;
   logic         dedge;
   logic         do_reset_clock;
   logic [31:0]  reset_clock;
   logic         step;
   logic         dir;
   logic [31:0]  position;
   logic         missed_clock;
   logic         queue_overflow;
   logic         idle;

   int checks = 0;
   int failures = 0;
   int base = 0;
   logic [31:0] exp_pos = 32'd0;

   int rise_q[$];
   int fall_q[$];
   int edge_q[$];
   int width_q[$];
   int margin_q[$];
   int hi_cnt = 0;
   int dir_chg_t = 0;
   logic prev_step = 1'b0;
   logic prev_dir = 1'b0;

   typedef struct packed {
      logic            d;
      logic [31:0]     ival;
      logic [31:0]     cnt;
      logic [31:0]     add;
      logic [15:0]     add2;
      logic [31:0]     n;
      logic [31:0]     pdelta;
      logic [4:0][31:0] rise;
   } vec_t;

   vec_t vecs [6];

   stepdir_accel dut (
      .clk            (clk),
      .reset          (reset),
      .clock          (sys_time),
      .queue_wr_data  (queue_wr_data),
      .queue_wr_en    (queue_wr_en),
      .queue_full     (queue_full),
      .queue_empty    (queue_empty),
      .queue_level    (queue_level),
      .dedge          (dedge),
      .do_reset_clock (do_reset_clock),
      .reset_clock    (reset_clock),
      .step           (step),
      .dir            (dir),
      .position       (position),
      .missed_clock   (missed_clock),
      .queue_overflow (queue_overflow),
      .idle           (idle)
   );

   always #5 clk = ~clk;

   // System time restarts at 0 with reset, like the DUT's time base.
   always @(posedge clk) begin
      if (reset) sys_time <= 32'd0;
      else       sys_time <= sys_time + 32'd1;
   end

   // Edge times are recorded as the clock value the DUT saw at the edge that caused them.
   always @(negedge clk) begin
      if (dir !== prev_dir) dir_chg_t = int'(sys_time) - 1;
      if (step !== prev_step) edge_q.push_back(int'(sys_time) - 1);
      if (step === 1'b1 && prev_step === 1'b0) begin
         rise_q.push_back(int'(sys_time) - 1);
         margin_q.push_back(int'(sys_time) - 1 - dir_chg_t);
         hi_cnt = 1;
      end else if (step === 1'b1) begin
         hi_cnt++;
      end
      if (step === 1'b0 && prev_step === 1'b1) begin
         fall_q.push_back(int'(sys_time) - 1);
         width_q.push_back(hi_cnt);
      end
      prev_step = step;
      prev_dir  = dir;
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   task automatic applyStimulus(input logic d, input logic [31:0] ival, input logic [31:0] cnt,
                                input logic [31:0] add, input logic [15:0] add2);
      queue_wr_data = {d, ival, cnt, add, add2};
      queue_wr_en   = 1'b1;
      tick;
      queue_wr_en   = 1'b0;
   endtask

   task automatic rebase(input int offset);
      base           = int'(sys_time);
      reset_clock    = sys_time + 32'(offset);
      do_reset_clock = 1'b1;
      tick;
      do_reset_clock = 1'b0;
   endtask

   task automatic clear_mon;
      rise_q.delete();
      fall_q.delete();
      edge_q.delete();
      width_q.delete();
      margin_q.delete();
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      while (!(idle && !step) && n < limit) begin
         tick;
         n++;
      end
      if (n >= limit) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s timeout: waited %0d cycles, required idle", name, n);
      end
      repeat (3) tick;
   endtask

   task automatic check_reset_state(input string tag);
      checkOutput({tag, " step"}, step, 0);
      checkOutput({tag, " dir"}, dir, 0);
      checkOutput({tag, " position"}, position, 0);
      checkOutput({tag, " missed"}, missed_clock, 0);
      checkOutput({tag, " overflow"}, queue_overflow, 0);
      checkOutput({tag, " idle"}, idle, 1);
      checkOutput({tag, " empty"}, queue_empty, 1);
      checkOutput({tag, " full"}, queue_full, 0);
      checkOutput({tag, " level"}, queue_level, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      vecs[0] = '{d:1'b1, ival:32'd1000, cnt:32'd4, add:-32'sd100, add2:16'sd10, n:32'd4, pdelta:32'd4,
                  rise:{32'd0, 32'd3440, 32'd2710, 32'd1900, 32'd1000}};
      vecs[1] = '{d:1'b0, ival:32'd50, cnt:32'd2, add:32'sd10, add2:16'sd0, n:32'd2, pdelta:-32'sd2,
                  rise:{32'd0, 32'd0, 32'd0, 32'd110, 32'd50}};
      vecs[2] = '{d:1'b1, ival:32'd30, cnt:32'd5, add:32'sd5, add2:-16'sd2, n:32'd5, pdelta:32'd5,
                  rise:{32'd180, 32'd142, 32'd103, 32'd65, 32'd30}};
      vecs[3] = '{d:1'b1, ival:32'd20, cnt:32'd1, add:32'sd7, add2:16'sd3, n:32'd1, pdelta:32'd1,
                  rise:{32'd0, 32'd0, 32'd0, 32'd0, 32'd20}};
      vecs[4] = '{d:1'b0, ival:32'd40, cnt:32'd3, add:32'sd0, add2:-16'sd5, n:32'd3, pdelta:-32'sd3,
                  rise:{32'd0, 32'd0, 32'd115, 32'd80, 32'd40}};
      vecs[5] = '{d:1'b0, ival:32'd64, cnt:32'd2, add:-32'sd32, add2:16'sd16, n:32'd2, pdelta:-32'sd2,
                  rise:{32'd0, 32'd0, 32'd0, 32'd96, 32'd64}};

      reset          = 1'b1;
      queue_wr_data  = '0;
      queue_wr_en    = 1'b0;
      dedge          = 1'b0;
      do_reset_clock = 1'b0;
      reset_clock    = 32'd0;
      repeat (3) tick;
      reset = 1'b0;
      tick;
      check_reset_state("reset");

      // Basic move from clock 0: steps at 100, 200, 300.
      clear_mon;
      applyStimulus(1'b1, 32'd100, 32'd3, 32'd0, 16'd0);
      wait_idle("basic", 2000);
      exp_pos = 32'd3;
      checkOutput("basic nsteps", rise_q.size(), 3);
      for (int k = 0; k < 3; k++) begin
         if (k < rise_q.size()) checkOutput($sformatf("basic rise%0d", k), rise_q[k], 100 * (k + 1));
      end
      foreach (width_q[k]) checkOutput($sformatf("basic width%0d", k), width_q[k], 8);
      checkOutput("basic position", position, exp_pos);
      checkOutput("basic missed", missed_clock, 0);

      for (int i = 0; i < 6; i++) begin
         clear_mon;
         rebase(0);
         applyStimulus(vecs[i].d, vecs[i].ival, vecs[i].cnt, vecs[i].add, vecs[i].add2);
         wait_idle($sformatf("v%0d", i), 10000);
         exp_pos = exp_pos + vecs[i].pdelta;
         checkOutput($sformatf("v%0d nsteps", i), rise_q.size(), vecs[i].n);
         for (int k = 0; k < int'(vecs[i].n); k++) begin
            if (k < rise_q.size())
               checkOutput($sformatf("v%0d rise%0d", i, k), 32'(rise_q[k] - base), vecs[i].rise[k]);
         end
         foreach (width_q[k]) checkOutput($sformatf("v%0d width%0d", i, k), width_q[k], 8);
         checkOutput($sformatf("v%0d position", i), position, exp_pos);
         checkOutput($sformatf("v%0d dir", i), dir, vecs[i].d);
         checkOutput($sformatf("v%0d missed", i), missed_clock, 0);
      end

      // Back-to-back moves with opposite dir: dir flips after the pulse ends.
      clear_mon;
      rebase(0);
      applyStimulus(1'b1, 32'd100, 32'd2, 32'd0, 16'd0);
      applyStimulus(1'b0, 32'd100, 32'd2, 32'd0, 16'd0);
      wait_idle("dirflip", 2000);
      checkOutput("dirflip nsteps", rise_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < rise_q.size()) checkOutput($sformatf("dirflip rise%0d", k), 32'(rise_q[k] - base), 100 * (k + 1));
      end
      foreach (margin_q[k]) checkOutput($sformatf("dirflip setup%0d", k), (margin_q[k] >= 4), 1);
      if (fall_q.size() >= 2) checkOutput("dirflip after pulse", (dir_chg_t > fall_q[1]), 1);
      checkOutput("dirflip dir", dir, 0);
      checkOutput("dirflip position", position, exp_pos);

      // Dwell move advances the time base without stepping.
      clear_mon;
      rebase(0);
      applyStimulus(1'b0, 32'd200, 32'd0, 32'd0, 16'd0);
      applyStimulus(1'b0, 32'd50, 32'd1, 32'd0, 16'd0);
      wait_idle("dwell", 2000);
      exp_pos = exp_pos - 32'd1;
      checkOutput("dwell nsteps", rise_q.size(), 1);
      if (rise_q.size() > 0) checkOutput("dwell rise", 32'(rise_q[0] - base), 250);
      checkOutput("dwell position", position, exp_pos);

      // Dual-edge mode: each step toggles the pin.
      dedge = 1'b1;
      clear_mon;
      rebase(0);
      applyStimulus(1'b1, 32'd20, 32'd4, 32'd0, 16'd0);
      wait_idle("dedge", 2000);
      dedge = 1'b0;
      exp_pos = exp_pos + 32'd4;
      checkOutput("dedge nedges", edge_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < edge_q.size()) checkOutput($sformatf("dedge edge%0d", k), 32'(edge_q[k] - base), 20 * (k + 1));
      end
      checkOutput("dedge position", position, exp_pos);
      checkOutput("dedge missed", missed_clock, 0);

      // Time base already in the past: late flag, step emitted right away.
      clear_mon;
      rebase(-10);
      applyStimulus(1'b1, 32'd5, 32'd1, 32'd0, 16'd0);
      wait_idle("late", 200);
      exp_pos = exp_pos + 32'd1;
      checkOutput("late missed", missed_clock, 1);
      checkOutput("late nsteps", rise_q.size(), 1);
      if (rise_q.size() > 0) checkOutput("late rise", 32'(rise_q[0] - base), 4);
      checkOutput("late position", position, exp_pos);

      // Park the engine on a far-future step, then fill the FIFO and overrun it.
      applyStimulus(1'b1, 32'h1000_0000, 32'd1, 32'd0, 16'd0);
      for (int k = 0; k < 512; k++) applyStimulus(1'b0, 32'd10, 32'd1, 32'd0, 16'd0);
      checkOutput("fill level", queue_level, 512);
      checkOutput("fill full", queue_full, 1);
      checkOutput("fill overflow", queue_overflow, 0);
      checkOutput("fill idle", idle, 0);
      applyStimulus(1'b0, 32'd10, 32'd1, 32'd0, 16'd0);
      checkOutput("over overflow", queue_overflow, 1);
      checkOutput("over level", queue_level, 512);
      checkOutput("over full", queue_full, 1);

      reset = 1'b1;
      repeat (2) tick;
      reset = 1'b0;
      tick;
      check_reset_state("reset2");
      exp_pos = 32'd0;

      // Reset mid-move with two steps left and a second move queued.
      clear_mon;
      applyStimulus(1'b1, 32'd50, 32'd4, 32'd0, 16'd0);
      applyStimulus(1'b1, 32'd50, 32'd4, 32'd0, 16'd0);
      begin
         int n;
         n = 0;
         while (rise_q.size() < 2 && n < 1000) begin
            tick;
            n++;
         end
         if (n >= 1000) begin
            checks++;
            failures++;
            $display("[TB] FAIL abort timeout: waited %0d cycles, required 2 steps", n);
         end
      end
      checkOutput("abort pre step", step, 1);
      checkOutput("abort pre position", position, 2);
      checkOutput("abort pre empty", queue_empty, 0);
      reset = 1'b1;
      tick;
      checkOutput("abort step", step, 0);
      checkOutput("abort idle", idle, 1);
      checkOutput("abort position", position, 0);
      checkOutput("abort empty", queue_empty, 1);
      checkOutput("abort dir", dir, 0);
      reset = 1'b0;
      repeat (120) tick;
      checkOutput("abort quiet nsteps", rise_q.size(), 2);
      checkOutput("abort quiet position", position, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
